// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared types and default 720p timing constants for the HDMI timing generator
package hdmi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int HFP_720P   = 110;
  localparam int HSYNC_720P = 40;
  localparam int HBP_720P   = 220;
  localparam int VFP_720P   = 5;
  localparam int VSYNC_720P = 5;
  localparam int VBP_720P   = 20;

endpackage

// File: rtl/hdmi_timing_gen_if.sv
// rtl/hdmi_timing_gen_if.sv - pixel FIFO head and video output bundle
interface hdmi_timing_gen_if;

  logic [23:0] pixel_data;
  logic        pixel_empty;
  logic        pixel_rd;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        ve;

  modport master (
    input  pixel_data, pixel_empty,
    output pixel_rd, red, green, blue, hsync, vsync, ve
  );

  modport slave (
    output pixel_data, pixel_empty,
    input  pixel_rd, red, green, blue, hsync, vsync, ve
  );

endinterface

// File: rtl/hdmi_sync_counter.sv
// rtl/hdmi_sync_counter.sv - loadable wrap counter with runtime total and sync window decode
module hdmi_sync_counter #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] total,
  input  logic [W-1:0] sync_lo,
  input  logic [W-1:0] sync_hi,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         in_sync
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt     = cnt_q;
  assign wrap    = (cnt_q == total - W'(1));
  assign in_sync = (cnt_q >= sync_lo) && (cnt_q < sync_hi);

  // load has priority over counting; the count returns to zero after total-1
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  // counter register
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hdmi_timing_gen.sv
// rtl/hdmi_timing_gen.sv - video timing FSM, reader request pulses and pixel source mux
module hdmi_timing_gen
  import hdmi_pkg::*;
#(
  parameter int H_W        = 12,
  parameter int V_W        = 11,
  parameter int HFP        = HFP_720P,
  parameter int HSYNC      = HSYNC_720P,
  parameter int HBP        = HBP_720P,
  parameter int VFP        = VFP_720P,
  parameter int VSYNC      = VSYNC_720P,
  parameter int VBP        = VBP_720P,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int CHUNK_LOG2 = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [H_W-1:0]     hres,
  input  logic [V_W-1:0]     vres,
  input  logic [31:0]        color,
  hdmi_timing_gen_if.master  vid,
  output logic               read_go,
  output logic               read_next_line,
  output logic               read_next_chunk,
  output logic               read_done,
  output logic               underflow
);

  localparam logic [H_W-1:0] H_BLANK = H_W'(HFP + HSYNC + HBP);
  localparam logic [V_W-1:0] V_BLANK = V_W'(VFP + VSYNC + VBP);

  state_t         state_q, state_d;
  logic [H_W-1:0] hres_q, hres_d, hcnt, htotal, hs_lo, hs_hi;
  logic [V_W-1:0] vres_q, vres_d, vcnt, vtotal, vs_lo, vs_hi, v_load_val;
  logic           h_wrap, hs_win, vs_win, unused_v_wrap, unused_color;
  logic           run, go, cnt_load, latch, active;

  logic hsync_q, hsync_d, vsync_q, vsync_d, ve_q, ve_d;
  logic go_q, go_d, line_q, line_d, chunk_q, chunk_d, done_q, done_d;
  logic underflow_q, underflow_d;
  rgb_t rgb_q, rgb_d;

  assign htotal = hres_q + H_BLANK;
  assign vtotal = vres_q + V_BLANK;
  assign hs_lo  = hres_q + H_W'(HFP);
  assign hs_hi  = hres_q + H_W'(HFP + HSYNC);
  assign vs_lo  = vres_q + V_W'(VFP);
  assign vs_hi  = vres_q + V_W'(VFP + VSYNC);

  assign run        = (state_q == RUN);
  assign go         = (state_q == IDLE) && (state_d == RUN);
  assign cnt_load   = go || (state_d == IDLE);
  assign v_load_val = go ? vres : '0;
  assign latch      = go || (run && hcnt == '0 && vcnt == vres_q);
  assign active     = run && (hcnt < hres_q) && (vcnt < vres_q);

  assign unused_color = ^color[7:0];

  hdmi_sync_counter #(.W(H_W)) u_hcnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .en       (1'b1),
    .load_val ('0),
    .total    (htotal),
    .sync_lo  (hs_lo),
    .sync_hi  (hs_hi),
    .cnt      (hcnt),
    .wrap     (h_wrap),
    .in_sync  (hs_win)
  );

  hdmi_sync_counter #(.W(V_W)) u_vcnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .en       (h_wrap),
    .load_val (v_load_val),
    .total    (vtotal),
    .sync_lo  (vs_lo),
    .sync_hi  (vs_hi),
    .cnt      (vcnt),
    .wrap     (unused_v_wrap),
    .in_sync  (vs_win)
  );

  // start needs a non-zero resolution; stopping only happens on the last pixel of the last active line
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && hres != '0 && vres != '0) state_d = RUN;
      RUN:     if (!start && h_wrap && vcnt == vres_q - V_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // resolution is only picked up at frame start so a frame never mixes geometries
  always_comb begin
    hres_d = hres_q;
    vres_d = vres_q;
    if (latch) begin
      hres_d = hres;
      vres_d = vres;
    end
  end

  // decodes of the current counter position, presented one cycle later
  always_comb begin
    hsync_d     = (run && hs_win) ? HS_POL : ~HS_POL;
    vsync_d     = (run && vs_win) ? VS_POL : ~VS_POL;
    ve_d        = active;
    go_d        = run && hcnt == '0 && vcnt == vres_q;
    line_d      = run && hcnt == hres_q && vcnt < vres_q - V_W'(1);
    done_d      = run && hcnt == hres_q && vcnt == vres_q - V_W'(1);
    chunk_d     = active && hcnt[CHUNK_LOG2-1:0] == '0;
    underflow_d = underflow_q | (active & mode & vid.pixel_empty);
    rgb_d       = '0;
    if (active) begin
      if (!mode)                 rgb_d = rgb_t'(color[31:8]);
      else if (!vid.pixel_empty) rgb_d = rgb_t'(vid.pixel_data);
    end
  end

  // state, latched resolution and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      hres_q      <= '0;
      vres_q      <= '0;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      ve_q        <= 1'b0;
      go_q        <= 1'b0;
      line_q      <= 1'b0;
      chunk_q     <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      hres_q      <= hres_d;
      vres_q      <= vres_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      ve_q        <= ve_d;
      go_q        <= go_d;
      line_q      <= line_d;
      chunk_q     <= chunk_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
      rgb_q       <= rgb_d;
    end
  end

  assign vid.pixel_rd    = active && mode && !vid.pixel_empty;
  assign vid.red         = rgb_q.r;
  assign vid.green       = rgb_q.g;
  assign vid.blue        = rgb_q.b;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.ve          = ve_q;
  assign read_go         = go_q;
  assign read_next_line  = line_q;
  assign read_next_chunk = chunk_q;
  assign read_done       = done_q;
  assign underflow       = underflow_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// tb/tb_hdmi_timing_gen.sv - directed self-checking bench for hdmi_timing_gen (hres 16, vres 4, htotal 26, vtotal 8)
module tb_hdmi_timing_gen;

  logic        clock = 1'b0;
  logic        reset, start, mode;
  logic [11:0] hres;
  logic [10:0] vres;
  logic [31:0] color;
  logic        read_go, read_next_line, read_next_chunk, read_done, underflow;

  int n_checks = 0;
  int n_pass   = 0;
  int head     = 0;
  int pops     = 0;

  hdmi_timing_gen_if vid();

  hdmi_timing_gen #(
    .H_W(12), .V_W(11), .HFP(2), .HSYNC(3), .HBP(5),
    .VFP(1), .VSYNC(2), .VBP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CHUNK_LOG2(2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .mode            (mode),
    .hres            (hres),
    .vres            (vres),
    .color           (color),
    .vid             (vid),
    .read_go         (read_go),
    .read_next_line  (read_next_line),
    .read_next_chunk (read_next_chunk),
    .read_done       (read_done),
    .underflow       (underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":ve"}, vid.ve, 0);
    check({tag, ":hsync"}, vid.hsync, 0);
    check({tag, ":vsync"}, vid.vsync, 0);
    check({tag, ":rgb"}, {vid.red, vid.green, vid.blue}, 0);
    check({tag, ":go"}, read_go, 0);
    check({tag, ":line"}, read_next_line, 0);
    check({tag, ":chunk"}, read_next_chunk, 0);
    check({tag, ":done"}, read_done, 0);
    check({tag, ":pixel_rd"}, vid.pixel_rd, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    start = 1'b0;
    vid.pixel_empty = 1'b0;
    head = 0;
    vid.pixel_data = 24'd0;
    tick();
    tick();
    check_idle(tag);
    check({tag, ":underflow"}, underflow, 0);
    reset = 1'b0;
  endtask

  // leaves the bench at the sample showing outputs for position 0 (hcnt 0, vcnt vres)
  task automatic start_run();
    start = 1'b1;
    tick();
    check("go_not_yet", read_go, 0);
    tick();
  endtask

  task automatic run_frames(input int n_pos, input bit fifo, input int empty_pos,
                            input int drop_at, output int n_pops);
    int h, v, f, idle_from, exp_rgb, nh, nv;
    bit idle, act, nact, pop;
    n_pops = 0;
    idle_from = 1 << 30;
    if (drop_at >= 0) begin
      idle_from = 208;
      while (idle_from - 1 < drop_at) idle_from += 208;
    end
    for (int s = 0; s < n_pos; s++) begin
      h    = s % 26;
      v    = (4 + s / 26) % 8;
      f    = (s / 26 + 4) / 8 - 1;
      idle = (s >= idle_from);
      act  = !idle && h < 16 && v < 4;
      exp_rgb = 0;
      if (act) begin
        if (!fifo) exp_rgb = 32'h112233;
        else if (s == empty_pos) exp_rgb = 0;
        else exp_rgb = f * 64 + v * 16 + h - ((empty_pos >= 0 && s > empty_pos) ? 1 : 0);
      end
      check($sformatf("ve@%0d", s), vid.ve, act);
      check($sformatf("hsync@%0d", s), vid.hsync, !idle && h >= 18 && h < 21);
      check($sformatf("vsync@%0d", s), vid.vsync, !idle && v >= 5 && v < 7);
      check($sformatf("go@%0d", s), read_go, !idle && h == 0 && v == 4);
      check($sformatf("line@%0d", s), read_next_line, !idle && h == 16 && v < 3);
      check($sformatf("done@%0d", s), read_done, !idle && h == 16 && v == 3);
      check($sformatf("chunk@%0d", s), read_next_chunk, act && (h % 4) == 0);
      check($sformatf("rgb@%0d", s), {vid.red, vid.green, vid.blue}, exp_rgb);
      check($sformatf("underflow@%0d", s), underflow, fifo && empty_pos >= 0 && s >= empty_pos);
      vid.pixel_empty = (s + 1 == empty_pos);
      if (drop_at >= 0 && s + 1 >= drop_at) start = 1'b0;
      @(negedge clock);
      nh   = (s + 1) % 26;
      nv   = (4 + (s + 1) / 26) % 8;
      nact = (s + 1 < idle_from) && nh < 16 && nv < 4;
      check($sformatf("pixel_rd@%0d", s + 1), vid.pixel_rd, nact && fifo && !vid.pixel_empty);
      pop = vid.pixel_rd;
      if (pop) n_pops++;
      @(posedge clock);
      #1;
      if (pop) begin
        head++;
        vid.pixel_data = 24'(head);
      end
    end
    vid.pixel_empty = 1'b0;
  endtask

  initial begin
    int ve0, ve1, hs1, run_len, max_run1, go_cnt;
    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    hres  = 12'd16;
    vres  = 11'd4;
    color = 32'h11223300;
    vid.pixel_data  = 24'd0;
    vid.pixel_empty = 1'b0;

    // sync timing and request pulses with the solid colour source
    do_reset("reset");
    start_run();
    run_frames(416, 1'b0, -1, -1, pops);
    check("solid_pops", pops, 0);

    // incrementing FIFO never empty
    do_reset("reset_fifo");
    mode = 1'b1;
    start_run();
    run_frames(416, 1'b1, -1, -1, pops);
    check("fifo_pops", pops, 128);

    // one empty active cycle at line 1 pixel 5, then a reset mid-line clears underflow
    do_reset("reset_uf");
    start_run();
    run_frames(525, 1'b1, 135, -1, pops);
    check("uf_pops", pops, 133);
    check("uf_sticky", underflow, 1);
    check("midline_rd_live", vid.pixel_rd, 1);
    reset = 1'b1;
    tick();
    check_idle("reset_mid");
    check("reset_mid:underflow", underflow, 0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check_idle("after_reset_mid");

    // start dropped mid-frame: frame 0 finishes, then IDLE with no read_go at position 208
    do_reset("reset_stop");
    mode = 1'b0;
    start_run();
    run_frames(240, 1'b0, -1, 150, pops);
    check_idle("stopped");

    // hres changed mid-frame only applies from the next frame start
    do_reset("reset_latch");
    start_run();
    ve0 = 0; ve1 = 0; hs1 = 0; run_len = 0; max_run1 = 0;
    for (int s = 0; s < 352; s++) begin
      if (s < 208) begin
        ve0 += int'(vid.ve);
      end else begin
        ve1 += int'(vid.ve);
        hs1 += int'(vid.hsync);
        run_len = vid.ve ? run_len + 1 : 0;
        if (run_len > max_run1) max_run1 = run_len;
      end
      if (s == 280) check("latch_ve_first", vid.ve, 1);
      if (s == 288) check("latch_ve_end", vid.ve, 0);
      if (s == 130) hres = 12'd8;
      tick();
    end
    check("latch_ve_frame0", ve0, 64);
    check("latch_ve_frame1", ve1, 32);
    check("latch_hsync_frame1", hs1, 24);
    check("latch_run_len", max_run1, 8);
    check("latch_go_frame2", read_go, 1);

    // zero horizontal resolution never leaves IDLE
    do_reset("reset_zero");
    hres  = 12'd0;
    start = 1'b1;
    go_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      go_cnt += int'(read_go) + int'(vid.ve) + int'(vid.hsync);
    end
    check("zero_hres_activity", go_cnt, 0);
    check_idle("zero_hres");
    hres = 12'd16;
    tick();
    tick();
    check("nonzero_hres_go", read_go, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
